// File: rtl/trap_pkg.sv
// trap_pkg -- shared definitions for the trap sequencer.
//
// Contents: privilege-level codes, return-type codes, cause constants and
// priority orders, the sequencer FSM state enum, the latched-action enum,
// mstatus bit positions, the mstatus reset value / write mask, and a helper
// that legalizes a software mstatus write.
package trap_pkg;

  localparam int XLEN_LEGAL = 64;

  // Privilege levels
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  // ret_type encodings (2'b10 is reserved and behaves as "no return")
  localparam logic [1:0] RET_SRET = 2'b01;
  localparam logic [1:0] RET_MRET = 2'b11;

  // Cause used when an xRET is not permitted at the current privilege
  localparam logic [3:0] CAUSE_ILLEGAL_INST = 4'd2;

  // Interrupt priority, highest first: MEI, MSI, MTI, SEI, SSI, STI
  localparam int INTR_PRIO_N = 6;
  localparam logic [3:0] INTR_PRIO [INTR_PRIO_N] = '{4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5};

  // Synchronous exception priority, highest first (causes 10 and 14 never taken)
  localparam int EXC_PRIO_N = 14;
  localparam logic [3:0] EXC_PRIO [EXC_PRIO_N] = '{4'd3, 4'd12, 4'd1, 4'd2, 4'd0, 4'd8, 4'd9,
                                                   4'd11, 4'd4, 4'd6, 4'd5, 4'd7, 4'd13, 4'd15};

  // Sequencer FSM
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_SAVE     = 2'b01,
    ST_REDIRECT = 2'b10
  } trap_state_e;

  // Action captured at accept and applied during SAVE
  typedef enum logic [1:0] {
    ACT_TRAP_M = 2'b00,
    ACT_TRAP_S = 2'b01,
    ACT_MRET   = 2'b10,
    ACT_SRET   = 2'b11
  } trap_act_e;

  // mstatus bit positions
  localparam int MS_SIE    = 1;
  localparam int MS_MIE    = 3;
  localparam int MS_SPIE   = 5;
  localparam int MS_MPIE   = 7;
  localparam int MS_SPP    = 8;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;
  localparam int MS_UXL_LO = 32;
  localparam int MS_SXL_LO = 34;

  // UXL = SXL = 2'b10 (64-bit); these are the only non-zero read-only bits
  localparam logic [63:0] MSTATUS_RESET = 64'(2) << MS_UXL_LO | 64'(2) << MS_SXL_LO;

  // SIE, MIE, SPIE, MPIE, SPP, MPP
  localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_19AA;

  // Software write: keep only writable fields, force XLs, and map the
  // reserved MPP encoding 2'b10 onto U.
  function automatic logic [63:0] mstatus_legalize(input logic [63:0] wdata);
    logic [63:0] r;
    r = (wdata & MSTATUS_WMASK) | MSTATUS_RESET;
    if (wdata[MS_MPP_HI:MS_MPP_LO] == 2'b10) begin
      r[MS_MPP_HI:MS_MPP_LO] = PRIV_U;
    end
    return r;
  endfunction

endpackage

// File: rtl/trap_cause_encoder.sv
// trap_cause_encoder -- combinational selection of the trap cause.
//
// Gates each pending interrupt by the current privilege and the global
// enables (routing it to S when delegated below M), then priority-encodes
// the takeable interrupts and the raised exceptions independently.
//
// Ports:
//   exc_vec    in  16  raised exception causes
//   intr_vec   in  12  pending-and-enabled interrupts
//   mideleg    in  12  interrupt delegation mask
//   priv       in   2  current privilege
//   mie, sie   in   1  mstatus global interrupt enables
//   intr_take  out  1  some interrupt is takeable
//   intr_cause out  4  highest-priority takeable interrupt
//   intr_to_s  out  1  that interrupt is delegated to S
//   exc_take   out  1  some prioritized exception is raised
//   exc_cause  out  4  highest-priority exception
module trap_cause_encoder
  import trap_pkg::*;
(
  input  logic [15:0] exc_vec,
  input  logic [11:0] intr_vec,
  input  logic [11:0] mideleg,
  input  logic [1:0]  priv,
  input  logic        mie,
  input  logic        sie,
  output logic        intr_take,
  output logic [3:0]  intr_cause,
  output logic        intr_to_s,
  output logic        exc_take,
  output logic [3:0]  exc_cause
);

  logic [11:0] deleg_i;
  logic [11:0] takeable_i;

  // Delegation only applies below M; a delegated interrupt is governed by
  // the S-mode enable, everything else by the M-mode rule.
  always_comb begin
    deleg_i = (priv != PRIV_M) ? mideleg : 12'd0;
    for (int n = 0; n < 12; n++) begin
      if (deleg_i[n]) begin
        takeable_i[n] = intr_vec[n] & ((priv == PRIV_U) | ((priv == PRIV_S) & sie));
      end else begin
        takeable_i[n] = intr_vec[n] & ((priv != PRIV_M) | mie);
      end
    end
  end

  // Walk from lowest to highest priority so the highest one wins.
  always_comb begin
    intr_take  = 1'b0;
    intr_cause = 4'd0;
    for (int i = INTR_PRIO_N - 1; i >= 0; i--) begin
      if (takeable_i[INTR_PRIO[i]]) begin
        intr_take  = 1'b1;
        intr_cause = INTR_PRIO[i];
      end
    end
    intr_to_s = intr_take & deleg_i[intr_cause];
  end

  always_comb begin
    exc_take  = 1'b0;
    exc_cause = 4'd0;
    for (int i = EXC_PRIO_N - 1; i >= 0; i--) begin
      if (exc_vec[EXC_PRIO[i]]) begin
        exc_take  = 1'b1;
        exc_cause = EXC_PRIO[i];
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer -- trap entry / xRET sequencer owning the M/S trap CSRs.
//
// Accepts a trap/return event in IDLE, captures the decision (SAVE), applies
// the CSR and privilege update, then holds a PC redirect until fetch takes it.
//   IDLE --accept--> SAVE --CSR update--> REDIRECT --redirect_ready--> IDLE
//
// Build option: define TRAP_SEQ_VECTORED_EN to enable vectored interrupt
// dispatch (tvec[1:0]==01 -> base + 4*cause). Without it the low two tvec
// bits are ignored and every trap goes to the aligned base.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid / req_ready       event handshake (ready only in IDLE)
//   exc_vec, intr_vec, ret_type event description from the committing inst
//   inst_pc, exc_tval           faulting PC and trap value
//   medeleg, mideleg            delegation masks
//   mtvec, stvec                trap vector bases
//   mstatus_wen, mstatus_wdata  software mstatus write (IDLE only)
//   redirect_valid/ready/target PC redirect to fetch
//   priv_mode                   current privilege
//   mstatus, mepc, mcause, mtval, sepc, scause, stval  owned CSRs
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [15:0]     exc_vec,
  input  logic [11:0]     intr_vec,
  input  logic [1:0]      ret_type,
  input  logic [XLEN-1:0] inst_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic [15:0]     medeleg,
  input  logic [11:0]     mideleg,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] stvec,
  input  logic            mstatus_wen,
  input  logic [XLEN-1:0] mstatus_wdata,
  input  logic            redirect_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_target,
  output logic [1:0]      priv_mode,
  output logic [XLEN-1:0] mstatus,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mtval,
  output logic [XLEN-1:0] sepc,
  output logic [XLEN-1:0] scause,
  output logic [XLEN-1:0] stval
);

  if (XLEN != XLEN_LEGAL) begin : g_xlen_check
    $error("trap_sequencer: XLEN must be 64");
  end

  // Architectural / control state
  trap_state_e     state_q, state_d;
  logic            req_ready_q, req_ready_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_target_q, redirect_target_d;
  logic [1:0]      priv_q, priv_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] sepc_q, sepc_d;
  logic [XLEN-1:0] scause_q, scause_d;
  logic [XLEN-1:0] stval_q, stval_d;

  // Decision captured at accept, consumed in SAVE
  trap_act_e       act_kind_q, act_kind_d;
  logic [3:0]      act_cause_q, act_cause_d;
  logic            act_intr_q, act_intr_d;
  logic [XLEN-1:0] act_pc_q, act_pc_d;
  logic [XLEN-1:0] act_tval_q, act_tval_d;

  // Cause selection
  logic       intr_take, intr_to_s, exc_take;
  logic [3:0] intr_cause, exc_cause;

  trap_cause_encoder u_cause_enc (
    .exc_vec    (exc_vec),
    .intr_vec   (intr_vec),
    .mideleg    (mideleg),
    .priv       (priv_q),
    .mie        (mstatus_q[MS_MIE]),
    .sie        (mstatus_q[MS_SIE]),
    .intr_take  (intr_take),
    .intr_cause (intr_cause),
    .intr_to_s  (intr_to_s),
    .exc_take   (exc_take),
    .exc_cause  (exc_cause)
  );

  // Accept-time decode of the incoming event
  logic            is_mret, is_sret, ret_illegal, below_m;
  logic            acc_event, acc_intr;
  trap_act_e       acc_kind;
  logic [3:0]      acc_cause;
  logic [XLEN-1:0] acc_tval, acc_tvec, acc_target;
  logic            handshake;

  assign handshake = req_valid & req_ready_q;

  always_comb begin
    below_m     = (priv_q != PRIV_M);
    is_mret     = (ret_type == RET_MRET);
    is_sret     = (ret_type == RET_SRET);
    ret_illegal = (is_mret & below_m) | (is_sret & (priv_q == PRIV_U));

    acc_event = 1'b1;
    acc_intr  = 1'b0;
    acc_kind  = ACT_TRAP_M;
    acc_cause = 4'd0;
    acc_tval  = '0;
    if (intr_take) begin
      acc_intr  = 1'b1;
      acc_cause = intr_cause;
      acc_kind  = intr_to_s ? ACT_TRAP_S : ACT_TRAP_M;
    end else if (exc_take) begin
      acc_cause = exc_cause;
      acc_tval  = exc_tval;
      acc_kind  = (below_m & medeleg[exc_cause]) ? ACT_TRAP_S : ACT_TRAP_M;
    end else if (ret_illegal) begin
      // Disallowed xRET becomes an illegal-instruction trap with tval 0
      acc_cause = CAUSE_ILLEGAL_INST;
      acc_kind  = (below_m & medeleg[CAUSE_ILLEGAL_INST]) ? ACT_TRAP_S : ACT_TRAP_M;
    end else if (is_mret) begin
      acc_kind = ACT_MRET;
    end else if (is_sret) begin
      acc_kind = ACT_SRET;
    end else begin
      acc_event = 1'b0;
    end
  end

  // Redirect target
  always_comb begin
    acc_tvec   = (acc_kind == ACT_TRAP_S) ? stvec : mtvec;
    acc_target = {acc_tvec[XLEN-1:2], 2'b00};
`ifdef TRAP_SEQ_VECTORED_EN
    if (acc_intr && (acc_tvec[1:0] == 2'b01)) begin
      acc_target = acc_target + {{(XLEN-6){1'b0}}, acc_cause, 2'b00};
    end
`endif
    if (acc_kind == ACT_MRET) begin
      acc_target = mepc_q;
    end else if (acc_kind == ACT_SRET) begin
      acc_target = sepc_q;
    end
  end

`ifndef TRAP_SEQ_VECTORED_EN
  // Mode bits are ignored in the non-vectored build
  logic unused_tvec_mode;
  assign unused_tvec_mode = ^{mtvec[1:0], stvec[1:0]};
`endif

  // Next-state logic
  always_comb begin
    state_d           = state_q;
    req_ready_d       = req_ready_q;
    redirect_valid_d  = redirect_valid_q;
    redirect_target_d = redirect_target_q;
    priv_d            = priv_q;
    mstatus_d         = mstatus_q;
    mepc_d            = mepc_q;
    mcause_d          = mcause_q;
    mtval_d           = mtval_q;
    sepc_d            = sepc_q;
    scause_d          = scause_q;
    stval_d           = stval_q;
    act_kind_d        = act_kind_q;
    act_cause_d       = act_cause_q;
    act_intr_d        = act_intr_q;
    act_pc_d          = act_pc_q;
    act_tval_d        = act_tval_q;

    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          // A handshake with nothing to take leaves everything untouched,
          // including any concurrent mstatus write.
          if (acc_event) begin
            state_d           = ST_SAVE;
            req_ready_d       = 1'b0;
            act_kind_d        = acc_kind;
            act_cause_d       = acc_cause;
            act_intr_d        = acc_intr;
            act_pc_d          = inst_pc;
            act_tval_d        = acc_tval;
            redirect_target_d = acc_target;
          end
        end else if (mstatus_wen) begin
          mstatus_d = mstatus_legalize(mstatus_wdata);
        end
      end

      ST_SAVE: begin
        state_d          = ST_REDIRECT;
        redirect_valid_d = 1'b1;
        case (act_kind_q)
          ACT_TRAP_M: begin
            mcause_d                       = {act_intr_q, {(XLEN-5){1'b0}}, act_cause_q};
            mepc_d                         = act_pc_q;
            mtval_d                        = act_tval_q;
            mstatus_d[MS_MPP_HI:MS_MPP_LO] = priv_q;
            mstatus_d[MS_MPIE]             = mstatus_q[MS_MIE];
            mstatus_d[MS_MIE]              = 1'b0;
            priv_d                         = PRIV_M;
          end
          ACT_TRAP_S: begin
            scause_d            = {act_intr_q, {(XLEN-5){1'b0}}, act_cause_q};
            sepc_d              = act_pc_q;
            stval_d             = act_tval_q;
            mstatus_d[MS_SPP]   = priv_q[0];
            mstatus_d[MS_SPIE]  = mstatus_q[MS_SIE];
            mstatus_d[MS_SIE]   = 1'b0;
            priv_d              = PRIV_S;
          end
          ACT_MRET: begin
            priv_d                         = mstatus_q[MS_MPP_HI:MS_MPP_LO];
            mstatus_d[MS_MIE]              = mstatus_q[MS_MPIE];
            mstatus_d[MS_MPIE]             = 1'b1;
            mstatus_d[MS_MPP_HI:MS_MPP_LO] = PRIV_U;
          end
          default: begin // ACT_SRET
            priv_d             = {1'b0, mstatus_q[MS_SPP]};
            mstatus_d[MS_SIE]  = mstatus_q[MS_SPIE];
            mstatus_d[MS_SPIE] = 1'b1;
            mstatus_d[MS_SPP]  = 1'b0;
          end
        endcase
      end

      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_d          = ST_IDLE;
          redirect_valid_d = 1'b0;
          req_ready_d      = 1'b1;
        end
      end

      default: begin
        state_d          = ST_IDLE;
        redirect_valid_d = 1'b0;
        req_ready_d      = 1'b1;
      end
    endcase
  end

  // State registers; reset discards any in-flight event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      req_ready_q       <= 1'b1;
      redirect_valid_q  <= 1'b0;
      redirect_target_q <= '0;
      priv_q            <= PRIV_M;
      mstatus_q         <= MSTATUS_RESET;
      mepc_q            <= '0;
      mcause_q          <= '0;
      mtval_q           <= '0;
      sepc_q            <= '0;
      scause_q          <= '0;
      stval_q           <= '0;
      act_kind_q        <= ACT_TRAP_M;
      act_cause_q       <= 4'd0;
      act_intr_q        <= 1'b0;
      act_pc_q          <= '0;
      act_tval_q        <= '0;
    end else begin
      state_q           <= state_d;
      req_ready_q       <= req_ready_d;
      redirect_valid_q  <= redirect_valid_d;
      redirect_target_q <= redirect_target_d;
      priv_q            <= priv_d;
      mstatus_q         <= mstatus_d;
      mepc_q            <= mepc_d;
      mcause_q          <= mcause_d;
      mtval_q           <= mtval_d;
      sepc_q            <= sepc_d;
      scause_q          <= scause_d;
      stval_q           <= stval_d;
      act_kind_q        <= act_kind_d;
      act_cause_q       <= act_cause_d;
      act_intr_q        <= act_intr_d;
      act_pc_q          <= act_pc_d;
      act_tval_q        <= act_tval_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign redirect_valid  = redirect_valid_q;
  assign redirect_target = redirect_target_q;
  assign priv_mode       = priv_q;
  assign mstatus         = mstatus_q;
  assign mepc            = mepc_q;
  assign mcause          = mcause_q;
  assign mtval           = mtval_q;
  assign sepc            = sepc_q;
  assign scause          = scause_q;
  assign stval           = stval_q;

endmodule
